// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the Tomasulo reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int ROB_DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] ROB_FULL_COUNT = (ROB_WIDTH + 1)'(ROB_DEPTH);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_JALR   = 2'd3
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred_taken;
        logic [31:0] target;
    } rob_entry_t;

    // x0 is hard-wired, so only non-zero destinations produce a register write.
    function automatic logic writes_rd(input rob_type_e kind, input logic [4:0] rd);
        return ((kind == TYPE_REG) || (kind == TYPE_JALR)) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-lookup and commit signals between the core and the reorder buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic                 issueFlag;
    logic [1:0]           issueType;
    logic [4:0]           issueRd;
    logic                 issuePredTaken;
    logic                 robFull;
    logic [ROB_WIDTH-1:0] issueId;
    logic [ROB_WIDTH-1:0] query1Id;
    logic [ROB_WIDTH-1:0] query2Id;
    logic                 query1Ready;
    logic                 query2Ready;
    logic [31:0]          query1Value;
    logic [31:0]          query2Value;
    logic                 cdbFlag;
    logic [ROB_WIDTH-1:0] cdbId;
    logic [31:0]          cdbValue;
    logic                 cdbTaken;
    logic [31:0]          cdbTarget;
    logic                 writeFlag;
    logic [ROB_WIDTH-1:0] robId;
    logic [4:0]           writeAddr;
    logic [31:0]          writeValue;
    logic                 storeCommitFlag;
    logic                 clearOut;
    logic [31:0]          pcOut;

    modport master (
        output issueFlag, issueType, issueRd, issuePredTaken,
        output query1Id, query2Id,
        output cdbFlag, cdbId, cdbValue, cdbTaken, cdbTarget,
        input  robFull, issueId, query1Ready, query2Ready, query1Value, query2Value,
        input  writeFlag, robId, writeAddr, writeValue, storeCommitFlag, clearOut, pcOut
    );

    modport slave (
        input  issueFlag, issueType, issueRd, issuePredTaken,
        input  query1Id, query2Id,
        input  cdbFlag, cdbId, cdbValue, cdbTaken, cdbTarget,
        output robFull, issueId, query1Ready, query2Ready, query1Value, query2Value,
        output writeFlag, robId, writeAddr, writeValue, storeCommitFlag, clearOut, pcOut
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, captures CDB results, answers
// operand lookups and retires one instruction per cycle in program order.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clockIn,
    input  logic            resetIn,
    input  logic            readyIn,
    reorder_buffer_if.slave rob
);

    rob_entry_t           ent_q [ROB_DEPTH];
    rob_entry_t           ent_d [ROB_DEPTH];
    logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;
    logic                 write_flag_q, write_flag_d;
    logic                 store_flag_q, store_flag_d;
    logic                 clear_q, clear_d;
    logic [ROB_WIDTH-1:0] rob_id_q, rob_id_d;
    logic [4:0]           write_addr_q, write_addr_d;
    logic [31:0]          write_value_q, write_value_d;
    logic [31:0]          pc_q, pc_d;

    logic                 full_s, live_s, issue_s, cdb_s, commit_s, redirect_s;
    logic                 q1_hit_s, q2_hit_s;
    logic [31:0]          cdb_value_s;
    rob_entry_t           head_ent_s;

    assign full_s      = (count_q == ROB_FULL_COUNT);
    assign rob.robFull = full_s;
    assign rob.issueId = tail_q;

    // A result on the CDB this cycle is forwarded so dependants need not wait a cycle.
    assign q1_hit_s        = rob.cdbFlag && (rob.cdbId == rob.query1Id);
    assign q2_hit_s        = rob.cdbFlag && (rob.cdbId == rob.query2Id);
    assign rob.query1Ready = ent_q[rob.query1Id].busy && (ent_q[rob.query1Id].ready || q1_hit_s);
    assign rob.query2Ready = ent_q[rob.query2Id].busy && (ent_q[rob.query2Id].ready || q2_hit_s);
    assign rob.query1Value = q1_hit_s ? rob.cdbValue : ent_q[rob.query1Id].value;
    assign rob.query2Value = q2_hit_s ? rob.cdbValue : ent_q[rob.query2Id].value;

    assign rob.writeFlag       = write_flag_q;
    assign rob.storeCommitFlag = store_flag_q;
    assign rob.clearOut        = clear_q;
    assign rob.robId           = rob_id_q;
    assign rob.writeAddr       = write_addr_q;
    assign rob.writeValue      = write_value_q;
    assign rob.pcOut           = pc_q;

    // Decode issue, CDB capture and head retirement; the flush cycle ignores all inputs.
    always_comb begin
        live_s     = readyIn && !clear_q;
        head_ent_s = ent_q[head_q];
        issue_s    = live_s && rob.issueFlag && !full_s;
        cdb_s      = live_s && rob.cdbFlag && ent_q[rob.cdbId].busy;
        commit_s   = live_s && head_ent_s.busy && head_ent_s.ready;
        redirect_s = commit_s && ((head_ent_s.kind == TYPE_JALR) ||
                     ((head_ent_s.kind == TYPE_BRANCH) &&
                      (head_ent_s.value[0] != head_ent_s.pred_taken)));
        if (ent_q[rob.cdbId].kind == TYPE_BRANCH) begin
            cdb_value_s = {rob.cdbValue[31:1], rob.cdbTaken};
        end else begin
            cdb_value_s = rob.cdbValue;
        end
    end

    // Per-entry next state: flush wins, then retire, allocate and CDB capture.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (redirect_s) begin
                ent_d[i] = '0;
            end else if (commit_s && (head_q == ROB_WIDTH'(i))) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end else if (issue_s && (tail_q == ROB_WIDTH'(i))) begin
                ent_d[i] = '{busy: 1'b1, ready: 1'b0, kind: rob_type_e'(rob.issueType),
                             rd: rob.issueRd, value: 32'd0,
                             pred_taken: rob.issuePredTaken, target: 32'd0};
            end else if (cdb_s && (rob.cdbId == ROB_WIDTH'(i))) begin
                ent_d[i].ready  = 1'b1;
                ent_d[i].value  = cdb_value_s;
                ent_d[i].target = rob.cdbTarget;
            end else begin
                ent_d[i] = ent_q[i];
            end
        end
    end

    // Pointers, occupancy and the registered commit outputs.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_s) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_s) begin
                head_d = head_q + ROB_WIDTH'(1'b1);
            end else begin
                head_d = head_q;
            end
            if (issue_s) begin
                tail_d = tail_q + ROB_WIDTH'(1'b1);
            end else begin
                tail_d = tail_q;
            end
            case ({issue_s, commit_s})
                2'b10:   count_d = count_q + (ROB_WIDTH + 1)'(1'b1);
                2'b01:   count_d = count_q - (ROB_WIDTH + 1)'(1'b1);
                default: count_d = count_q;
            endcase
        end

        write_flag_d = commit_s && writes_rd(head_ent_s.kind, head_ent_s.rd);
        store_flag_d = commit_s && (head_ent_s.kind == TYPE_STORE);
        clear_d      = redirect_s;
        if (commit_s) begin
            rob_id_d      = head_q;
            write_addr_d  = head_ent_s.rd;
            write_value_d = head_ent_s.value;
        end else begin
            rob_id_d      = rob_id_q;
            write_addr_d  = write_addr_q;
            write_value_d = write_value_q;
        end
        if (redirect_s) begin
            pc_d = head_ent_s.target;
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; readyIn low freezes everything, outputs included.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            write_flag_q  <= 1'b0;
            store_flag_q  <= 1'b0;
            clear_q       <= 1'b0;
            rob_id_q      <= '0;
            write_addr_q  <= 5'd0;
            write_value_q <= 32'd0;
            pc_q          <= 32'd0;
        end else if (readyIn) begin
            ent_q         <= ent_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            write_flag_q  <= write_flag_d;
            store_flag_q  <= store_flag_d;
            clear_q       <= clear_d;
            rob_id_q      <= rob_id_d;
            write_addr_q  <= write_addr_d;
            write_value_q <= write_value_d;
            pc_q          <= pc_d;
        end
    end

endmodule
